// File: rtl/case_9_sdiv_14s_12s_14_seq_1.sv
// Multi-cycle signed divider (restoring radix-2), start/done handshake with ce stall; 16 ce-cycles accept-to-done.
// Optional CASE_9_SDIV_DBZ_FLAG_EN adds a registered divide-by-zero flag output (dbz).
module case_9_sdiv_14s_12s_14_seq_1 #(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 16,
    parameter int din0_WIDTH = 14,
    parameter int din1_WIDTH = 12,
    parameter int dout_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  start,
    output logic                  ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  done,
    output logic [dout_WIDTH-1:0] quot,
    output logic [din1_WIDTH-1:0] remd
`ifdef CASE_9_SDIV_DBZ_FLAG_EN
    ,
    output logic                  dbz
`endif
);

    localparam int AW = din0_WIDTH;
    localparam int BW = din1_WIDTH;
    localparam int CW = $clog2(din0_WIDTH);

    generate
        if (NUM_STAGE != din0_WIDTH + 2 || dout_WIDTH != din0_WIDTH || ID < 0) begin : g_bad_cfg
            $error("case_9 sdiv: inconsistent parameters");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

    state_t        state;
    logic [AW-1:0] a_q;
    logic [BW-1:0] b_q;
    logic          sign_a;
    logic          sign_q;
    logic [AW-1:0] dvd;     // dividend magnitude; quotient bits shift in from the LSB
    logic [BW:0]   dsr;
    logic [BW:0]   rem;
    logic [CW-1:0] cnt;

    // Magnitudes: the most-negative dividend is exact as an unsigned AW-bit value.
    logic [AW-1:0] a_mag;
    logic [BW:0]   b_ext;
    logic [BW:0]   b_mag;
    logic [BW+1:0] rem_sh;
    logic [BW:0]   diff;
    logic          ge;
    logic          div_zero;

    assign a_mag    = a_q[AW-1] ? (~a_q + 1'b1) : a_q;
    assign b_ext    = {b_q[BW-1], b_q};
    assign b_mag    = b_q[BW-1] ? (~b_ext + 1'b1) : b_ext;
    assign rem_sh   = {rem, dvd[AW-1]};
    assign ge       = (rem_sh >= {1'b0, dsr});
    assign diff     = rem_sh[BW:0] - dsr;
    assign div_zero = (b_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            ready  <= 1'b1;
            done   <= 1'b0;
            quot   <= '0;
            remd   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            sign_a <= 1'b0;
            sign_q <= 1'b0;
            dvd    <= '0;
            dsr    <= '0;
            rem    <= '0;
            cnt    <= '0;
`ifdef CASE_9_SDIV_DBZ_FLAG_EN
            dbz    <= 1'b0;
`endif
        end else if (ce) begin
            // done clears only on an enabled edge, so a stalled pulse is stretched.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= din0;
                        b_q   <= din1;
                        ready <= 1'b0;
                        state <= PREP;
                    end
                end
                PREP: begin
                    sign_a <= a_q[AW-1];
                    sign_q <= a_q[AW-1] ^ b_q[BW-1];
                    dvd    <= a_mag;
                    dsr    <= b_mag;
                    rem    <= '0;
                    cnt    <= CW'(NUM_STAGE - 3);
                    state  <= ITER;
                end
                ITER: begin
                    rem <= ge ? diff : rem_sh[BW:0];
                    dvd <= {dvd[AW-2:0], ge};
                    if (cnt == '0) begin
                        state <= FIX;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                FIX: begin
                    if (div_zero) begin
                        quot <= '1;
                        remd <= a_q[BW-1:0];
                    end else begin
                        quot <= dout_WIDTH'(sign_q ? (~dvd + 1'b1) : dvd);
                        remd <= sign_a ? (~rem[BW-1:0] + 1'b1) : rem[BW-1:0];
                    end
`ifdef CASE_9_SDIV_DBZ_FLAG_EN
                    dbz   <= div_zero;
`endif
                    done  <= 1'b1;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_case_9_sdiv_14s_12s_14_seq_1.sv
// Bench for the signed sequential divider: directed table, random vs. arithmetic model, stall/handshake/reset sequences.
module tb_case_9_sdiv_14s_12s_14_seq_1;

    logic        clk = 1'b0;
    logic        reset, ce, start, ready, done;
    logic [13:0] din0, quot;
    logic [11:0] din1, remd;
`ifdef CASE_9_SDIV_DBZ_FLAG_EN
    logic        dbz;
`endif

    case_9_sdiv_14s_12s_14_seq_1 dut (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .start (start),
        .ready (ready),
        .din0  (din0),
        .din1  (din1),
        .done  (done),
        .quot  (quot),
        .remd  (remd)
`ifdef CASE_9_SDIV_DBZ_FLAG_EN
        ,
        .dbz   (dbz)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference: plain integer division truncating toward zero, with the divide-by-zero rule.
    task automatic model(input logic [13:0] a, input logic [11:0] b,
                         output logic [13:0] q, output logic [11:0] r);
        int ai, bi, qi, ri;
        ai = int'($signed(a));
        bi = int'($signed(b));
        if (bi == 0) begin
            qi = -1;
            ri = ai;
        end else begin
            qi = ai / bi;
            ri = ai % bi;
        end
        q = qi[13:0];
        r = ri[11:0];
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic launch(input logic [13:0] a, input logic [11:0] b);
        din0  = a;
        din1  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    typedef struct {
        logic [13:0] a;
        logic [11:0] b;
        logic [13:0] q;
        logic [11:0] r;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int          lat, lat2, ndone, dlat;
        logic [13:0] eq, q0, cq;
        logic [11:0] er, r0, cr, rb;
        logic [13:0] ra;

        vecs[0] = '{14'h0064, 12'h007, 14'h000E, 12'h002};  //  100 /  7
        vecs[1] = '{14'h3F9C, 12'h007, 14'h3FF2, 12'hFFE};  // -100 /  7
        vecs[2] = '{14'h0064, 12'hFF9, 14'h3FF2, 12'h002};  //  100 / -7
        vecs[3] = '{14'h3F9C, 12'hFF9, 14'h000E, 12'hFFE};  // -100 / -7
        vecs[4] = '{14'h2000, 12'hFFF, 14'h2000, 12'h000};  // -8192 / -1
        vecs[5] = '{14'h2000, 12'h001, 14'h2000, 12'h000};  // -8192 / 1
        vecs[6] = '{14'h1FFF, 12'h800, 14'h3FFD, 12'h7FF};  // 8191 / -2048
        vecs[7] = '{14'h0005, 12'h000, 14'h3FFF, 12'h005};  // 5 / 0
        vecs[8] = '{14'h0009, 12'h003, 14'h0003, 12'h000};  // 9 / 3
        vecs[9] = '{14'h03E8, 12'h00D, 14'h004C, 12'h00C};  // 1000 / 13

        reset = 1'b1;
        ce    = 1'b1;
        start = 1'b0;
        din0  = '0;
        din1  = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_done",  done,  0);
        check("rst_quot",  quot,  0);
        check("rst_remd",  remd,  0);
`ifdef CASE_9_SDIV_DBZ_FLAG_EN
        check("rst_dbz",   dbz,   0);
`endif
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            launch(vecs[i].a, vecs[i].b);
            wait_done(lat);
            check($sformatf("vec%0d_latency", i), lat, 16);
            check($sformatf("vec%0d_quot", i), quot, vecs[i].q);
            check($sformatf("vec%0d_remd", i), remd, vecs[i].r);
            check($sformatf("vec%0d_ready", i), ready, 1);
`ifdef CASE_9_SDIV_DBZ_FLAG_EN
            check($sformatf("vec%0d_dbz", i), dbz, (vecs[i].b == 12'h000) ? 1 : 0);
`endif
        end

        for (int i = 0; i < 30; i++) begin
            ra = 14'($urandom);
            case ($urandom_range(0, 9))
                0:       rb = 12'h000;
                1:       rb = 12'hFFF;
                default: rb = 12'($urandom);
            endcase
            model(ra, rb, eq, er);
            @(negedge clk);
            launch(ra, rb);
            wait_done(lat);
            check($sformatf("rnd%0d_latency", i), lat, 16);
            check($sformatf("rnd%0d_quot(%0h/%0h)", i, ra, rb), quot, eq);
            check($sformatf("rnd%0d_remd(%0h/%0h)", i, ra, rb), remd, er);
        end

        // ce stall mid-iteration, then a stretched done pulse.
        @(negedge clk);
        q0 = quot;
        r0 = remd;
        launch(14'h03E8, 12'h00D);
        lat = 0;
        while (done !== 1'b1 && lat < 200) begin
            if (lat == 5)  ce = 1'b0;
            if (lat == 10) ce = 1'b1;
            @(negedge clk);
            lat++;
            if (lat >= 6 && lat <= 10) begin
                check("stall_quot", quot, q0);
                check("stall_remd", remd, r0);
                check("stall_ready", ready, 0);
            end
        end
        check("stall_latency", lat, 21);
        check("stall_quot_res", quot, 14'h004C);
        check("stall_remd_res", remd, 12'h00C);
        ce = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("done_stretch", done, 1);
            check("done_stretch_quot", quot, 14'h004C);
        end
        ce = 1'b1;
        @(negedge clk);
        check("done_after_stretch", done, 0);

        // start pulses while busy are ignored.
        @(negedge clk);
        launch(14'h0064, 12'h007);
        lat   = 0;
        ndone = 0;
        dlat  = -1;
        cq    = '0;
        cr    = '0;
        while (lat < 40) begin
            if (lat == 3 || lat == 7 || lat == 11) begin
                din0  = 14'h0037;
                din1  = 12'h005;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
            if (done === 1'b1) begin
                ndone++;
                dlat = lat;
                cq   = quot;
                cr   = remd;
            end
        end
        start = 1'b0;
        check("busy_done_count", ndone, 1);
        check("busy_latency", dlat, 16);
        check("busy_quot", cq, 14'h000E);
        check("busy_remd", cr, 12'h002);

        // Back-to-back: second start accepted in the done cycle.
        @(negedge clk);
        launch(14'h0064, 12'h007);
        wait_done(lat);
        check("b2b_first_latency", lat, 16);
        launch(14'h3F9C, 12'h007);
        wait_done(lat2);
        check("b2b_second_latency", lat2, 16);
        check("b2b_quot", quot, 14'h3FF2);
        check("b2b_remd", remd, 12'hFFE);

        // Reset mid-operation aborts the work in flight.
        @(negedge clk);
        launch(14'h03E8, 12'h00D);
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_ready", ready, 1);
        check("midrst_done",  done,  0);
        check("midrst_quot",  quot,  0);
        check("midrst_remd",  remd,  0);
        reset = 1'b0;
        ndone = 0;
        repeat (30) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("midrst_no_done", ndone, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
